// File: rtl/div_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : div_iter_pkg                                               |
// | Brief   : Shared widths, state encodings and handshake constants for |
// |           the iterative divider.                                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_iter_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Two's-complement negation, used both for magnitudes and sign restore.
  function automatic logic [RegBus-1:0] twos_neg(input logic [RegBus-1:0] v);
    return ~v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : div_iter_if                                                |
// | Brief   : Request/result handshake between execute and the divider.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface div_iter_if;
  import div_iter_pkg::*;

  logic                    signed_div_i;
  logic [RegBus-1:0]       opdata1_i;
  logic [RegBus-1:0]       opdata2_i;
  logic                    start_i;
  logic                    annul_i;
  logic [DoubleRegBus-1:0] result_o;
  logic                    ready_o;

  // Execute stage side
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // Divider side
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface
`default_nettype wire

// File: rtl/div_iter_sign_fix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : div_sign_fix                                               |
// | Brief   : Combinational sign handling: operand magnitudes on entry,  |
// |           quotient/remainder negation on exit.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_sign_fix
  import div_iter_pkg::*;
(
  // entry side: raw operands from the request
  input  wire logic              signed_div,
  input  wire logic [RegBus-1:0] op1,
  input  wire logic [RegBus-1:0] op2,
  output logic      [RegBus-1:0] op1_mag,
  output logic      [RegBus-1:0] op2_mag,
  // exit side: unsigned result and captured operand signs
  input  wire logic              fix_signed,
  input  wire logic              fix_op1_neg,
  input  wire logic              fix_op2_neg,
  input  wire logic [RegBus-1:0] quot_raw,
  input  wire logic [RegBus-1:0] rem_raw,
  output logic      [RegBus-1:0] quot,
  output logic      [RegBus-1:0] rem
);

  // Negative operands are divided by magnitude only in signed mode.
  assign op1_mag = (signed_div && op1[31]) ? twos_neg(op1) : op1;
  assign op2_mag = (signed_div && op2[31]) ? twos_neg(op2) : op2;

  // Quotient is negative when signs differ; remainder follows the dividend.
  assign quot = (fix_signed && (fix_op1_neg ^ fix_op2_neg)) ? twos_neg(quot_raw) : quot_raw;
  assign rem  = (fix_signed && fix_op1_neg) ? twos_neg(rem_raw) : rem_raw;

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : div_iter                                                   |
// | Brief   : Iterative restoring radix-2 32-bit signed/unsigned divider |
// |           returning {remainder, quotient} after 32 iterations.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_iter
  import div_iter_pkg::*;
(
  input  wire logic   clk,
  input  wire logic   rst,
  div_iter_if.slave   bus
);

  div_state_e              state;
  logic [5:0]              cnt;
  logic [64:0]             dividend;
  logic [RegBus-1:0]       divisor;
  logic                    sign_mode;
  logic                    op1_neg;
  logic                    op2_neg;
  logic [DoubleRegBus-1:0] result;
  logic                    ready;

  logic [RegBus-1:0]       op1_mag;
  logic [RegBus-1:0]       op2_mag;
  logic [RegBus-1:0]       minuend;
  logic [32:0]             diff;
  logic [64:0]             next_dividend;
  logic [RegBus-1:0]       quot_fixed;
  logic [RegBus-1:0]       rem_fixed;

  // One restoring step: subtract when the partial remainder allows it.
  assign minuend       = dividend[63:32];
  assign diff          = {1'b0, minuend} - {1'b0, divisor};
  assign next_dividend = diff[32] ? {dividend[63:0], 1'b0}
                                  : {diff[31:0], dividend[31:0], 1'b1};

  div_sign_fix u_sign_fix (
    .signed_div  (bus.signed_div_i),
    .op1         (bus.opdata1_i),
    .op2         (bus.opdata2_i),
    .op1_mag     (op1_mag),
    .op2_mag     (op2_mag),
    .fix_signed  (sign_mode),
    .fix_op1_neg (op1_neg),
    .fix_op2_neg (op2_neg),
    .quot_raw    (next_dividend[31:0]),
    .rem_raw     (next_dividend[64:33]),
    .quot        (quot_fixed),
    .rem         (rem_fixed)
  );

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

  // Divider control: accept, iterate, present result until execute releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DivFree;
      cnt       <= 6'd0;
      dividend  <= 65'd0;
      divisor   <= '0;
      sign_mode <= 1'b0;
      op1_neg   <= 1'b0;
      op2_neg   <= 1'b0;
      result    <= '0;
      ready     <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          if (bus.start_i == DivStart && !bus.annul_i) begin
            sign_mode <= bus.signed_div_i;
            op1_neg   <= bus.signed_div_i & bus.opdata1_i[31];
            op2_neg   <= bus.signed_div_i & bus.opdata2_i[31];
            if (bus.opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              cnt      <= 6'd0;
              dividend <= {32'd0, op1_mag, 1'b0};
              divisor  <= op2_mag;
            end
          end
        end
        DivByZero: begin
          // Division by zero is defined to return all zeros.
          dividend <= 65'd0;
          result   <= '0;
          ready    <= DivResultReady;
          state    <= DivEnd;
        end
        DivOn: begin
          if (bus.annul_i) begin
            state <= DivFree;
            cnt   <= 6'd0;
          end else begin
            dividend <= next_dividend;
            cnt      <= cnt + 6'd1;
            // Final iteration folds in the sign restore so END is reached directly.
            if (cnt == 6'd31) begin
              result <= {rem_fixed, quot_fixed};
              ready  <= DivResultReady;
              state  <= DivEnd;
              cnt    <= 6'd0;
            end
          end
        end
        DivEnd: begin
          if (bus.start_i == DivStop) begin
            state  <= DivFree;
            result <= '0;
            ready  <= DivResultNotReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_div_iter                                                |
// | Brief   : Self-checking bench for div_iter with a result scoreboard. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_div_iter;
  import div_iter_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  div_iter_if bus ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference divider built on native 64-bit arithmetic.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for ready, compare against the scoreboard, then release.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int hold);
    int          cyc;
    bit          seen;
    logic [63:0] e;
    int          l;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    exp_q.push_back(expv);
    lat_q.push_back((b == 32'd0) ? 2 : 33);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      step();
      cyc++;
      if (cyc == 1) begin
        // operands were captured on the accepting edge; disturb them
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      if (bus.ready_o) seen = 1'b1;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!seen) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      check("latency", 64'(cyc), 64'(l));
      check("result", bus.result_o, e);
      for (int k = 0; k < hold; k++) begin
        step();
        check("hold_ready", 64'(bus.ready_o), 64'd1);
        check("hold_result", bus.result_o, e);
      end
    end
    bus.start_i = 1'b0;
    step();
    check("drop_ready", 64'(bus.ready_o), 64'd0);
    check("drop_result", bus.result_o, 64'd0);
  endtask

  // Watch ready for a number of cycles; it must stay low.
  task automatic expect_idle(input string tag, input int cycles);
    bit any;
    any = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (bus.ready_o) any = 1'b1;
    end
    check(tag, 64'(any), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) step();
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    step();

    // Directed cases with hand-derived results
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 0);
    run_div(1'b0, 32'd1234, 32'd0, 64'd0, 0);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 64'd0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
    run_div(1'b0, 32'd999, 32'd10, {32'd9, 32'd99}, 5);

    // Abort around iteration 10; no result may appear
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (10) step();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    step();
    bus.annul_i = 1'b0;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    expect_idle("annul_idle", 40);
    run_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 0);

    // Annul while idle blocks acceptance
    bus.opdata1_i = 32'd50;
    bus.opdata2_i = 32'd5;
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b1;
    expect_idle("annul_free_idle", 40);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    step();

    // Reset in the middle of an iteration
    bus.opdata1_i = 32'd12345;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (5) step();
    rst = 1'b1;
    step();
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_result", bus.result_o, 64'd0);
    rst         = 1'b0;
    bus.start_i = 1'b0;
    expect_idle("midrst_idle", 40);

    // Mixed random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      s = i[0];
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 5) a = 32'h8000_0000;
      run_div(s, a, b, model(s, a, b), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
